// File: rtl/kbd_pkg.sv
// Shared constants, FSM state encoding and key-classification helpers for the keyboard encoder.
package kbd_pkg;

   localparam logic [7:0] ESC_CODE  = 8'h1B;

   localparam logic [7:0] KEY_UP    = 8'h80;
   localparam logic [7:0] KEY_DOWN  = 8'h81;
   localparam logic [7:0] KEY_RIGHT = 8'h82;
   localparam logic [7:0] KEY_LEFT  = 8'h83;

   localparam logic [7:0] SUF_UP    = 8'h41;
   localparam logic [7:0] SUF_DOWN  = 8'h42;
   localparam logic [7:0] SUF_RIGHT = 8'h43;
   localparam logic [7:0] SUF_LEFT  = 8'h44;

   typedef enum logic [1:0] {
      IDLE,
      PLAIN,
      ESC,
      SUFFIX
   } state_t;

   function automatic logic is_mapped(input logic [7:0] code);
      return code <= KEY_LEFT;
   endfunction

   function automatic logic is_arrow(input logic [7:0] code);
      return (code >= KEY_UP) && (code <= KEY_LEFT);
   endfunction

   // Arrow direction is carried as the low two bits of the key code.
   function automatic logic [7:0] suffix_of(input logic [1:0] dir);
      logic [7:0] letter;
      case (dir)
         KEY_UP[1:0]:    letter = SUF_UP;
         KEY_DOWN[1:0]:  letter = SUF_DOWN;
         KEY_RIGHT[1:0]: letter = SUF_RIGHT;
         default:        letter = SUF_LEFT;
      endcase
      return letter;
   endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Single-clock key FIFO with registered pointers and occupancy; head word is shown combinationally.
// Writes are ignored while full and reads while empty; full/empty reflect state before the edge.
module kbd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           i_wr_en,
   input  logic [WIDTH-1:0]               i_wr_data,
   input  logic                           i_rd_en,
   output logic [WIDTH-1:0]               o_rd_data,
   output logic                           o_full,
   output logic                           o_empty,
   output logic [$clog2(DEPTH+1)-1:0]     o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_wr;
   logic             w_rd;

   assign o_full    = (r_level == LW'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rd_data = r_mem[r_rd_ptr];
   assign w_wr      = i_wr_en & ~o_full;
   assign w_rd      = i_rd_en & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/kbd_encoder.sv
// USB key codes -> byte stream for a UART; arrows become ESC + letter. Strobe to tvalid is SYNC_STAGES+3 edges.
// Output holds under tready low; keys queue in the FIFO and are dropped with an overflow pulse when it is full.
module kbd_encoder #(
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [7:0]                     usb_kbd,
   input  logic                           kbd_strobe,
   output logic [7:0]                     m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           overflow,
   output logic                           bad_key,
   output logic [$clog2(DEPTH+1)-1:0]     fifo_level
);

   import kbd_pkg::*;

   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES-1:0] r_sync_ok;
   logic                   r_prev;
   logic                   r_cap;
   logic                   r_overflow;
   logic                   r_bad_key;

   state_t                 r_state;
   logic [7:0]             r_tdata;
   logic                   r_tvalid;
   logic [1:0]             r_dir;

   logic [7:0]             w_head;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_mapped;
   logic                   w_wr;
   logic                   w_accept;
   logic                   w_pop;

   assign w_mapped      = is_mapped(usb_kbd);
   assign w_wr          = r_cap & w_mapped;
   assign w_accept      = r_tvalid & m_axis_tready;
   assign w_pop         = ~w_empty & ((r_state == IDLE) |
                          (w_accept & ((r_state == PLAIN) | (r_state == SUFFIX))));

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign overflow      = r_overflow;
   assign bad_key       = r_bad_key;

   // r_prev sits at 1 until real samples reach the last stage, so a strobe
   // already high when reset releases is never seen as a rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync     <= '0;
         r_sync_ok  <= '0;
         r_prev     <= 1'b1;
         r_cap      <= 1'b0;
         r_overflow <= 1'b0;
         r_bad_key  <= 1'b0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], kbd_strobe};
         r_sync_ok  <= {r_sync_ok[SYNC_STAGES-2:0], 1'b1};
         r_prev     <= r_sync_ok[SYNC_STAGES-1] ? r_sync[SYNC_STAGES-1] : 1'b1;
         r_cap      <= r_sync_ok[SYNC_STAGES-1] & r_sync[SYNC_STAGES-1] & ~r_prev;
         r_overflow <= r_cap & w_mapped & w_full;
         r_bad_key  <= r_cap & ~w_mapped;
      end
   end

   kbd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_wr),
      .i_wr_data (usb_kbd),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (fifo_level)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_tdata  <= 8'h00;
         r_tvalid <= 1'b0;
         r_dir    <= 2'b00;
      end else begin
         case (r_state)
            ESC: begin
               if (w_accept) begin
                  r_state <= SUFFIX;
                  r_tdata <= suffix_of(r_dir);
               end
            end
            default: begin
               if (w_pop) begin
                  r_tvalid <= 1'b1;
                  if (is_arrow(w_head)) begin
                     r_state <= ESC;
                     r_tdata <= ESC_CODE;
                     r_dir   <= w_head[1:0];
                  end else begin
                     r_state <= PLAIN;
                     r_tdata <= w_head;
                  end
               end else if (w_accept) begin
                  r_state  <= IDLE;
                  r_tvalid <= 1'b0;
                  r_tdata  <= 8'h00;
               end
            end
         endcase
      end
   end

endmodule
